// File: rtl/c2c_link_sequencer_if.sv
// c2c_link_sequencer_if: control, status and Aurora sideband signals of the link sequencer
interface c2c_link_sequencer_if #(
  parameter int NUM_LANES = 2
);
  logic                 enable;
  logic                 force_retrain;
  logic                 clear_counters;
  logic                 gt_pll_lock;
  logic                 channel_up;
  logic [NUM_LANES-1:0] lane_up;
  logic                 soft_err;
  logic                 hard_err;
  logic                 reset_pb;
  logic                 pma_init;
  logic                 link_ready;
  logic [2:0]           state;
  logic [15:0]          retrain_count;
  logic [15:0]          soft_err_count;
  logic                 link_timeout;
  modport master (
    output enable, force_retrain, clear_counters, gt_pll_lock, channel_up, lane_up, soft_err, hard_err,
    input  reset_pb, pma_init, link_ready, state, retrain_count, soft_err_count, link_timeout
  );
  modport slave (
    input  enable, force_retrain, clear_counters, gt_pll_lock, channel_up, lane_up, soft_err, hard_err,
    output reset_pb, pma_init, link_ready, state, retrain_count, soft_err_count, link_timeout
  );
endinterface

// File: rtl/c2c_link_sequencer.sv
// c2c_link_sequencer: Aurora reset/bring-up sequencing, link qualification and retrain bookkeeping
module c2c_link_sequencer #(
  parameter int NUM_LANES       = 2,
  parameter int RESET_PB_CYCLES = 256,
  parameter int GT_RESET_CYCLES = 1024,
  parameter int GT_RELEASE_WAIT = 256,
  parameter int LINK_TIMEOUT    = 1048576,
  parameter int STABLE_CYCLES   = 1024
) (
  input logic                  clk,
  input logic                  rst,
  c2c_link_sequencer_if.slave  i_link
);
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PB_ASSERT   = 3'd1,
    PMA_ASSERT  = 3'd2,
    PMA_RELEASE = 3'd3,
    WAIT_UP     = 3'd4,
    STABLE      = 3'd5,
    READY       = 3'd6
  } state_e;
  localparam int          SW    = NUM_LANES + 4;
  localparam logic [31:0] T_PB  = 32'(RESET_PB_CYCLES - 1);
  localparam logic [31:0] T_GT  = 32'(GT_RESET_CYCLES - 1);
  localparam logic [31:0] T_REL = 32'(GT_RELEASE_WAIT - 1);
  localparam logic [31:0] T_TO  = 32'(LINK_TIMEOUT - 1);
  localparam logic [31:0] T_ST  = 32'(STABLE_CYCLES - 1);
  logic [SW-1:0] r_sync1, r_sync2;
  state_e        r_state, w_next;
  logic [31:0]   r_timer;
  logic          r_reset_pb, r_pma_init, r_link_ready, r_link_timeout;
  logic [15:0]   r_retrain_count, r_soft_err_count;
  logic          w_lock, w_soft, w_hard, w_up, w_retrain, w_tmo, w_enter;
  assign w_lock  = r_sync2[0];
  assign w_soft  = r_sync2[1];
  assign w_hard  = r_sync2[2];
  assign w_up    = r_sync2[3] & (&r_sync2[SW-1:4]);
  assign w_enter = (w_next != r_state) | w_retrain;
  // two-flop synchronizer for every asynchronous Aurora/GT status input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {i_link.lane_up, i_link.channel_up, i_link.hard_err, i_link.soft_err, i_link.gt_pll_lock};
      r_sync2 <= r_sync1;
    end
  end
  // next-state selection: enable beats force_retrain, which beats the normal sequence
  always_comb begin
    w_next    = r_state;
    w_retrain = 1'b0;
    w_tmo     = 1'b0;
    if (!i_link.enable) w_next = IDLE;
    else if (i_link.force_retrain && r_state != IDLE) begin
      w_next    = PB_ASSERT;
      w_retrain = 1'b1;
    end else begin
      case (r_state)
        IDLE:        w_next = PB_ASSERT;
        PB_ASSERT:   w_next = (r_timer == T_PB) ? PMA_ASSERT : PB_ASSERT;
        PMA_ASSERT:  w_next = (r_timer == T_GT) ? PMA_RELEASE : PMA_ASSERT;
        PMA_RELEASE: w_next = (r_timer >= T_REL && w_lock) ? WAIT_UP : PMA_RELEASE;
        WAIT_UP: begin
          if (w_up) w_next = STABLE;
          else if (r_timer == T_TO) begin
            w_next    = PB_ASSERT;
            w_retrain = 1'b1;
            w_tmo     = 1'b1;
          end
        end
        STABLE:      w_next = !w_up ? WAIT_UP : (r_timer == T_ST) ? READY : STABLE;
        READY: begin
          if (!w_up || w_hard) begin
            w_next    = PB_ASSERT;
            w_retrain = 1'b1;
          end
        end
        default:     w_next = IDLE;
      endcase
    end
  end
  // state, entry-cleared timer and outputs registered together so they move on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_reset_pb   <= 1'b1;
      r_pma_init   <= 1'b0;
      r_link_ready <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_timer      <= w_enter ? '0 : r_timer + 32'd1;
      r_reset_pb   <= w_next inside {IDLE, PB_ASSERT, PMA_ASSERT, PMA_RELEASE};
      r_pma_init   <= w_next == PMA_ASSERT;
      r_link_ready <= w_next == READY;
    end
  end
  // saturating retrain/soft-error counters and sticky timeout flag; clear has precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retrain_count  <= '0;
      r_soft_err_count <= '0;
      r_link_timeout   <= 1'b0;
    end else if (i_link.clear_counters) begin
      r_retrain_count  <= '0;
      r_soft_err_count <= '0;
      r_link_timeout   <= 1'b0;
    end else begin
      if (w_retrain && r_retrain_count != 16'hFFFF) r_retrain_count <= r_retrain_count + 16'd1;
      if (w_soft && r_state == READY && r_soft_err_count != 16'hFFFF) r_soft_err_count <= r_soft_err_count + 16'd1;
      if (w_tmo) r_link_timeout <= 1'b1;
    end
  end
  assign i_link.reset_pb       = r_reset_pb;
  assign i_link.pma_init       = r_pma_init;
  assign i_link.link_ready     = r_link_ready;
  assign i_link.state          = r_state;
  assign i_link.retrain_count  = r_retrain_count;
  assign i_link.soft_err_count = r_soft_err_count;
  assign i_link.link_timeout   = r_link_timeout;
endmodule

// File: tb/tb_c2c_link_sequencer.sv
// tb_c2c_link_sequencer: randomized scenarios against a transition-timeline scoreboard
module tb_c2c_link_sequencer;
  localparam int RPB = 4, GRC = 8, GRW = 4, LTO = 64, STC = 16;
  localparam logic [2:0] S_IDLE = 3'd0, S_PB = 3'd1, S_PMA = 3'd2, S_REL = 3'd3,
                         S_WAIT = 3'd4, S_STB = 3'd5, S_RDY = 3'd6;
  typedef struct {int at; logic [2:0] st; int rc; bit lt;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int   cyc = 0, vectors = 0, errors = 0, rc_m = 0;
  bit   lt_m = 1'b0;
  exp_t q[$];
  logic [2:0] last_st;
  c2c_link_sequencer_if #(.NUM_LANES(2)) link();
  c2c_link_sequencer #(
    .NUM_LANES(2), .RESET_PB_CYCLES(RPB), .GT_RESET_CYCLES(GRC), .GT_RELEASE_WAIT(GRW),
    .LINK_TIMEOUT(LTO), .STABLE_CYCLES(STC)
  ) dut (.clk(clk), .rst(rst), .i_link(link));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic void push(input int at, input logic [2:0] st);
    q.push_back('{at, st, rc_m, lt_m});
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic until_cyc(input int c);
    while (cyc < c) step(1);
  endtask
  // Aurora reset timeline from a PB_ASSERT entry edge; lock_at = first edge lock may be acted on
  task automatic seq(input int s, input int lock_at, input bit up, output int w);
    push(s + RPB, S_PMA);
    push(s + RPB + GRC, S_REL);
    w = (lock_at > s + RPB + GRC + GRW) ? lock_at : s + RPB + GRC + GRW;
    push(w, S_WAIT);
    if (up) push(w + 1, S_STB);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, link.state, S_IDLE);
    chk({tag, "_reset_pb"}, link.reset_pb, 1);
    chk({tag, "_pma_init"}, link.pma_init, 0);
    chk({tag, "_link_ready"}, link.link_ready, 0);
    chk({tag, "_retrain"}, link.retrain_count, 0);
    chk({tag, "_soft"}, link.soft_err_count, 0);
    chk({tag, "_timeout"}, link.link_timeout, 0);
  endtask
  // monitor: output decode every cycle, and each state change popped against the expected timeline
  always @(negedge clk) begin
    if (rst) last_st <= link.state;
    else begin
      chk("decode", {link.reset_pb, link.pma_init, link.link_ready},
          {link.state <= S_REL, link.state == S_PMA, link.state == S_RDY});
      if (link.state !== last_st) begin
        if (q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_transition: got state %0d from %0d, none expected (cycle %0d)", link.state, last_st, cyc);
        end else begin
          chk("transition_cycle", cyc, q[0].at);
          chk("transition_state", link.state, q[0].st);
          chk("retrain_count", link.retrain_count, q[0].rc);
          chk("link_timeout", link.link_timeout, q[0].lt);
          q.delete(0);
        end
        last_st <= link.state;
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int x, w, w2, k, g, xg, p, n, lk;
    link.enable = 0; link.force_retrain = 0; link.clear_counters = 0; link.gt_pll_lock = 1;
    link.channel_up = 1; link.lane_up = 2'b11; link.soft_err = 0; link.hard_err = 0;
    step(2);
    chk_reset("reset");
    rst = 0;
    step(3);
    chk("idle_hold", link.state, S_IDLE);
    // bring-up with everything already up
    x = cyc; link.enable = 1; push(x + 1, S_PB);
    seq(x + 1, 0, 1, w); push(w + 1 + STC, S_RDY);
    until_cyc(w + STC + 6);
    // random soft errors while READY
    k = 0;
    for (int i = 0; i < 20; i++) begin
      link.soft_err = 1'($urandom_range(0, 1));
      k += int'(link.soft_err);
      step(1);
    end
    link.soft_err = 0;
    step(4);
    chk("soft_err_count", link.soft_err_count, k);
    // lane loss in READY
    x = cyc; link.lane_up = 2'b01; rc_m++; push(x + 3, S_PB);
    step(3); link.lane_up = 2'b11;
    seq(x + 3, 0, 1, w); push(w + 1 + STC, S_RDY);
    until_cyc(w + STC + 6);
    // hard error in READY, then a one-cycle channel glitch during STABLE
    x = cyc; link.hard_err = 1; rc_m++; push(x + 3, S_PB);
    step(1); link.hard_err = 0;
    seq(x + 3, 0, 1, w);
    g = $urandom_range(5, 13); xg = w + 1 + g - 3;
    until_cyc(xg); link.channel_up = 0;
    push(xg + 3, S_WAIT); push(xg + 4, S_STB); push(xg + 20, S_RDY);
    step(1); link.channel_up = 1;
    until_cyc(xg + 25);
    // repeated WAIT_UP timeouts, then clear
    n = $urandom_range(2, 4);
    x = cyc; link.channel_up = 0; rc_m++; p = x + 3; push(p, S_PB);
    for (int i = 0; i < n; i++) begin
      seq(p, 0, 0, w);
      p = w + LTO; rc_m++; lt_m = 1; push(p, S_PB);
    end
    until_cyc(p + 2); link.clear_counters = 1; link.channel_up = 1;
    step(1); link.clear_counters = 0; rc_m = 0; lt_m = 0;
    chk("clear_retrain", link.retrain_count, 0);
    chk("clear_timeout", link.link_timeout, 0);
    seq(p, 0, 1, w); push(w + 1 + STC, S_RDY);
    until_cyc(w + STC + 6);
    // enable beats force_retrain; then force_retrain alone in WAIT_UP
    x = cyc; link.enable = 0; link.force_retrain = 1; push(x + 1, S_IDLE);
    step(1); link.force_retrain = 0; link.channel_up = 0;
    step(2);
    x = cyc; link.enable = 1; push(x + 1, S_PB);
    seq(x + 1, 0, 0, w);
    until_cyc(w + 3); link.force_retrain = 1; rc_m++; push(w + 4, S_PB);
    step(1); link.force_retrain = 0; link.channel_up = 1;
    seq(w + 4, 0, 1, w2); push(w2 + 1 + STC, S_RDY);
    until_cyc(w2 + STC + 6);
    // soft error counter saturation
    link.soft_err = 1;
    step(65540);
    link.soft_err = 0;
    step(4);
    chk("soft_err_saturate", link.soft_err_count, 16'hFFFF);
    // asynchronous reset in the middle of the pma_init pulse
    x = cyc; link.force_retrain = 1; rc_m++; push(x + 1, S_PB); push(x + 1 + RPB, S_PMA);
    step(1); link.force_retrain = 0;
    until_cyc(x + 7);
    chk("pma_before_rst", link.pma_init, 1);
    link.gt_pll_lock = 0; rst = 1;
    #1;
    chk_reset("rst_async");
    rc_m = 0; lt_m = 0;
    step(2);
    rst = 0;
    x = cyc; push(x + 1, S_PB);
    lk = x + 10 + $urandom_range(0, 20);
    seq(x + 1, lk + 3, 1, w); push(w + 1 + STC, S_RDY);
    until_cyc(lk); link.gt_pll_lock = 1;
    until_cyc(w + STC + 6);
    chk("final_state", link.state, S_RDY);
    chk("queue_empty", q.size(), 0);
    chk("final_soft", link.soft_err_count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/c2c_link_sequencer.md
Name: c2c_link_sequencer

Overview:
Bring-up and recovery controller for the Aurora chip-to-chip slave link (NUM_LANES lanes) on the VU13P. It runs the Aurora reset sequence: reset_pb asserted, then pma_init pulse, then release. It then waits for channel/lane up, qualifies link stability and declares link_ready. On timeout, link loss, hard error or software request it retrains, and it keeps saturating retrain and soft-error counters.

Parameters:
NUM_LANES, 2, Aurora lane count.
RESET_PB_CYCLES, 256, cycles in PB_ASSERT before pma_init.
GT_RESET_CYCLES, 1024, pma_init high time.
GT_RELEASE_WAIT, 256, minimum cycles after pma_init release before reset_pb release.
LINK_TIMEOUT, 1048576, maximum cycles in WAIT_UP.
STABLE_CYCLES, 1024, consecutive cycles of full link-up required before READY.

Ports:
clk  in  1  init clock; all logic in this domain.
rst  in  1  asynchronous, active-high reset.
enable  in  1  level; 0 forces IDLE.
force_retrain  in  1  single-cycle request to restart the sequence.
clear_counters  in  1  single-cycle clear of retrain_count, soft_err_count and link_timeout.
gt_pll_lock  in  1  async; GT PLL lock.
channel_up  in  1  async; Aurora channel_up.
lane_up  in  NUM_LANES  async; Aurora lane_up.
soft_err  in  1  async; Aurora soft_err.
hard_err  in  1  async; Aurora hard_err.
reset_pb  out  1  Aurora reset_pb.
pma_init  out  1  Aurora pma_init.
link_ready  out  1  link qualified; releases the C2C bridge.
state  out  3  current state encoding.
retrain_count  out  16  saturating count of retrains.
soft_err_count  out  16  saturating count of soft_err cycles in READY.
link_timeout  out  1  sticky; set on any WAIT_UP timeout.

Behaviour:
- Synchronizers: every async input passes through a 2-flop synchronizer. Logic sees an input change 2 cycles after the change; tests account for this latency.
- Reset values: state=IDLE, reset_pb=1, pma_init=0, link_ready=0, counters=0, link_timeout=0, timer=0.
- State encodings: IDLE=0, PB_ASSERT=1, PMA_ASSERT=2, PMA_RELEASE=3, WAIT_UP=4, STABLE=5, READY=6.
- Output decode: all outputs registered and decoded from the state register.
  - reset_pb=1 in IDLE, PB_ASSERT, PMA_ASSERT, PMA_RELEASE.
  - pma_init=1 only in PMA_ASSERT.
  - link_ready=1 only in READY.
- Timer: 32-bit, cleared on every state entry, increments each cycle. "After N cycles" means the exit occurs when timer==N-1, so the state is held exactly N cycles.
- "up" = synchronized channel_up & all lane_up bits.
- Transition priority:
  1. enable==0 -> IDLE from any state.
  2. force_retrain in any non-IDLE state -> PB_ASSERT, retrain_count+1.
  3. Normal transitions below.
- IDLE: enable==1 -> PB_ASSERT.
- PB_ASSERT: after RESET_PB_CYCLES -> PMA_ASSERT.
- PMA_ASSERT: after GT_RESET_CYCLES -> PMA_RELEASE.
- PMA_RELEASE: timer>=GT_RELEASE_WAIT-1 and gt_pll_lock==1 -> WAIT_UP; waits indefinitely for lock.
- WAIT_UP:
  - up -> STABLE.
  - Otherwise, at timer==LINK_TIMEOUT-1 -> PB_ASSERT, retrain_count+1, link_timeout=1.
- STABLE:
  - up drops for any cycle -> WAIT_UP (timer restarts; no count).
  - up held STABLE_CYCLES -> READY.
- READY: up==0 or hard_err==1 -> PB_ASSERT, retrain_count+1.
- soft_err_count: +1 per cycle with synchronized soft_err==1 while in READY.
- Counter limits: retrain_count and soft_err_count saturate at 0xFFFF.
- clear_counters: zeroes retrain_count, soft_err_count and link_timeout next cycle. If a count or timeout event occurs in the same cycle, clear wins.
- Output latency: outputs change the same edge as state, i.e. 1 cycle after the causing (synchronized) condition.
- rst mid-operation: all outputs return to reset values asynchronously. pma_init falls immediately even mid-pulse. On release the sequence restarts from IDLE.

Test Plan:
Bench parameters: RESET_PB_CYCLES=4, GT_RESET_CYCLES=8, GT_RELEASE_WAIT=4, LINK_TIMEOUT=64, STABLE_CYCLES=16.
1. Bring-up: enable=1, gt_pll_lock=1, channel_up and lane_up=2'b11 held from start -> PB_ASSERT 4 cycles, pma_init high exactly 8 cycles, reset_pb falls 4 cycles after pma_init falls, link_ready rises 16 cycles after STABLE entry, retrain_count=0.
2. Timeout: channel_up stuck 0 -> reset_pb reasserts after 64 WAIT_UP cycles, link_timeout=1, retrain_count=1; after 3 loops retrain_count=3; clear_counters -> retrain_count=0, link_timeout=0.
3. Glitch: channel_up low 1 cycle at STABLE cycle 10 -> state back to 4, link_ready stays 0 until 16 further stable cycles, retrain_count unchanged.
4. Link loss: in READY drive lane_up=2'b01 -> state=1 and reset_pb=1 3 cycles later, link_ready=0, retrain_count+1; hard_err pulse in READY -> same result.
5. Priority: force_retrain and enable=0 in the same cycle in READY -> state=0, retrain_count unchanged; force_retrain alone in WAIT_UP -> state=1, count+1.
6. Async reset while pma_init=1 -> pma_init=0 and state=0 before next clock edge; soft_err held through 70000 READY cycles -> soft_err_count=0xFFFF.
